// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising-edge detectors feeding sticky pending
// requests, served round-robin over a single valid/ready event port.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in         [N_CH] raw level inputs (synchronous to clk)
//   evt_valid  event offered; high only while the arbiter is in OFFER
//   evt_ready  consumer handshake
//   evt_id     [ID_W] channel of the offered event, stable while valid
//   ovf        [N_CH] sticky per-channel overflow (edge arrived while pending)
//   ovf_clr    one-cycle pulse clearing all ovf bits
//   dbg_state  arbiter state: 00 IDLE, 01 OFFER, 10 ACK

// edge_event_det: 3-state Moore rising-edge detector for one channel.
// Ports: clk, rst, in (level), edge_pulse (one cycle per 0->1 transition).
module edge_event_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic edge_pulse
);
  localparam logic [1:0] D_LOW  = 2'b00;
  localparam logic [1:0] D_RISE = 2'b01;
  localparam logic [1:0] D_HIGH = 2'b10;

  logic [1:0] st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= D_LOW;
    else begin
      case (st)
        D_LOW:   st <= in ? D_RISE : D_LOW;
        D_RISE:  st <= in ? D_HIGH : D_LOW;
        D_HIGH:  st <= in ? D_HIGH : D_LOW;
        default: st <= D_LOW;
      endcase
    end
  end

  assign edge_pulse = (st == D_RISE);
endmodule

module edge_event_arbiter #(
  parameter  int N_CH = 4,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr,
  output logic [1:0]      dbg_state
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_OFFER = 2'b01;
  localparam logic [1:0] S_ACK   = 2'b10;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [N_CH-1:0] edge_pulse;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] clr_mask;
  logic [N_CH-1:0] ovf_set;
  logic [ID_W-1:0] pick;
  logic            accept;
  int              best;

  edge_event_det u_det [N_CH-1:0] (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .edge_pulse (edge_pulse)
  );

  assign accept = (state == S_OFFER) && evt_ready;

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[evt_id] = 1'b1;
  end

  // A new edge on a channel whose request is being consumed this cycle
  // simply re-arms it; only an edge on a still-pending request is lost.
  assign ovf_set = edge_pulse & pending & ~clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | edge_pulse;
      ovf     <= (ovf_clr ? '0 : ovf) | ovf_set;
    end
  end

  // Round-robin pick: pending channel with the smallest distance from ptr
  // (distance measured upward, wrapping mod N_CH).
  always_comb begin
    pick = '0;
    best = N_CH;
    for (int i = 0; i < N_CH; i++) begin
      if (pending[i] && (((i + N_CH - int'(ptr)) % N_CH) < best)) begin
        best = (i + N_CH - int'(ptr)) % N_CH;
        pick = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      evt_id <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pending) begin
            state  <= S_OFFER;
            evt_id <= pick;
          end
        end
        S_OFFER: begin
          // No timeout: the grant is held until the consumer takes it.
          if (evt_ready) begin
            state <= S_ACK;
            ptr   <= (int'(evt_id) == N_CH - 1) ? '0 : evt_id + ID_W'(1);
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from the state flop, so no combinational path from
  // evt_ready or in to any output.
  assign evt_valid = (state == S_OFFER);
  assign dbg_state = state;
endmodule
